// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signal bundle for mem_port_arbiter.
// The arbiter uses the slave modport; requesters and the memory use master.
interface mem_port_arbiter_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = DATA_W / 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = 6
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*STRB_W-1:0] req_wstrb;
  logic [N_REQ-1:0]        resp_valid;
  logic                    resp_err;
  logic [DATA_W-1:0]       resp_rdata;
  logic                    mem_en;
  logic                    mem_we;
  logic [MEM_AW-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [STRB_W-1:0]       mem_wstrb;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, req_wstrb, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, req_wstrb, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between N_REQ requesters.
// Define MEM_ARB_LOCK_EN to let a requester hold the grant across a locked burst.
module mem_port_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned STRB_W    = DATA_W / 8,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned MEM_AW    = $clog2(MEM_DEPTH),
  parameter int unsigned ADDR_ST   = 0,
  parameter int unsigned ADDR_END  = 64
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]  rr_q, rr_d;
  logic              own_vld_q;
  logic [IDX_W-1:0]  own_q;
  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic [N_REQ-1:0]  ready_vec;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W:0]   addr_off;
  logic              in_range;
  logic              mem_hit;
  logic [N_REQ-1:0]  resp_valid_q;
  logic              resp_err_q, resp_err_d;
  logic              rd_q, rd_d;

  // Owner-only eligibility while locked, else first valid from rr with wrap.
  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    if (rst_n) begin
      if (own_vld_q) begin
        grant_vld = bus.req_valid[own_q];
        grant_idx = own_q;
      end else begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
          cand = 32'(rr_q) + k;
          if (cand >= N_REQ) cand = cand - N_REQ;
          cand_idx = IDX_W'(cand);
          if (!grant_vld && bus.req_valid[cand_idx]) begin
            grant_vld = 1'b1;
            grant_idx = cand_idx;
          end
        end
      end
    end
  end

  assign sel_addr = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
  // The borrow bit of the offset doubles as the lower-bound check.
  assign addr_off = {1'b0, sel_addr} - (ADDR_W + 1)'(ADDR_ST);
  assign in_range = !addr_off[ADDR_W] && ({1'b0, sel_addr} < (ADDR_W + 1)'(ADDR_END));
  assign mem_hit  = grant_vld && in_range;

  always_comb begin
    ready_vec     = '0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    if (grant_vld) ready_vec[grant_idx] = 1'b1;
    if (mem_hit) begin
      bus.mem_we    = bus.req_we[grant_idx];
      bus.mem_addr  = addr_off[MEM_AW-1:0];
      bus.mem_wdata = bus.req_wdata[grant_idx*DATA_W +: DATA_W];
      bus.mem_wstrb = bus.req_wstrb[grant_idx*STRB_W +: STRB_W];
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.mem_en    = mem_hit;

  always_comb begin
    rr_d = rr_q;
    if (grant_vld) rr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign resp_err_d = grant_vld && !in_range;
  assign rd_d       = mem_hit && !bus.req_we[grant_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q         <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      rd_q         <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      resp_valid_q <= ready_vec;
      resp_err_q   <= resp_err_d;
      rd_q         <= rd_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = (|resp_valid_q && rd_q) ? bus.mem_rdata : '0;

`ifdef MEM_ARB_LOCK_EN
  logic             own_vld_d;
  logic [IDX_W-1:0] own_d;

  // Out-of-range beats leave the lock untouched; only the owner can be granted while locked.
  always_comb begin
    own_vld_d = own_vld_q;
    own_d     = own_q;
    if (mem_hit) begin
      if (bus.req_lock[grant_idx]) begin
        own_vld_d = 1'b1;
        own_d     = grant_idx;
      end else begin
        own_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_vld_q <= 1'b0;
      own_q     <= '0;
    end else begin
      own_vld_q <= own_vld_d;
      own_q     <= own_d;
    end
  end
`else
  logic unused_lock;
  assign own_vld_q   = 1'b0;
  assign own_q       = '0;
  assign unused_lock = ^bus.req_lock;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a behavioural arbitration/memory model,
// plus directed contention, lock, range and reset scenarios.
module tb_mem_port_arbiter;
  localparam int unsigned N = 2, DW = 32, SW = 4, AW = 32, DEPTH = 64, MAW = 6;
  localparam int unsigned AST = 0, AEND = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N_REQ(N), .DATA_W(DW), .STRB_W(SW), .ADDR_W(AW), .MEM_AW(MAW)) bus ();

  mem_port_arbiter #(
    .N_REQ(N), .DATA_W(DW), .STRB_W(SW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .MEM_AW(MAW),
    .ADDR_ST(AST), .ADDR_END(AEND)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Requester stimulus
  logic [N-1:0]  v, we, lock;
  logic [31:0]   a[N];
  logic [31:0]   d[N];
  logic [3:0]    s[N];

  // Memory device seen by the DUT; preloaded with a pattern on every reset edge
  logic [DW-1:0] mem[DEPTH];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= (k + 1) * 32'h9E3779B9;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < SW; b++)
          if (bus.mem_wstrb[b]) mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem[DEPTH];
  int            rr_m = 0;
  bit            own_vld_m = 0;
  int            own_m = 0;
  bit            erv = 0;
  int            eidx = 0;
  bit            eerr = 0;
  logic [31:0]   erd = '0;
  int            last_g = -1;
  logic [N-1:0]  obs_ready;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] x);
    longint ax;
    ax = longint'(x);
    return (ax >= longint'(AST)) && (ax < longint'(AEND));
  endfunction

  function automatic int pick();
    if (!rst_n) return -1;
    if (own_vld_m) return v[own_m] ? own_m : -1;
    for (int k = 0; k < N; k++) if (v[(rr_m + k) % N]) return (rr_m + k) % N;
    return -1;
  endfunction

  task automatic apply();
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_lock  = lock;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = a[i];
      bus.req_wdata[i*DW +: DW] = d[i];
      bus.req_wstrb[i*SW +: SW] = s[i];
    end
  endtask

  task automatic set_req(input int i, input bit w, input bit l, input logic [31:0] ad,
                         input logic [31:0] dat, input logic [3:0] st);
    v[i] = 1'b1; we[i] = w; lock[i] = l; a[i] = ad; d[i] = dat; s[i] = st;
  endtask

  task automatic rand_req(input int i);
    logic [31:0] ad;
    ad = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 79));
    set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, ad, $urandom,
            4'($urandom_range(0, 15)));
  endtask

  // One clock: entered and left at negedge+1 with new inputs already in the arrays.
  task automatic cycle();
    int g;
    int idx;
    logic [N-1:0] er;
    apply();
    #1;
    g  = pick();
    er = (g >= 0) ? (N'(1) << g) : '0;
    obs_ready = bus.req_ready;
    check_eq("req_ready", bus.req_ready, er);
    if (g >= 0 && in_rng(a[g])) begin
      check_eq("mem_en", bus.mem_en, 1);
      check_eq("mem_we", bus.mem_we, we[g]);
      check_eq("mem_addr", bus.mem_addr, MAW'(a[g] - AST));
      check_eq("mem_wdata", bus.mem_wdata, d[g]);
      check_eq("mem_wstrb", bus.mem_wstrb, s[g]);
    end else begin
      check_eq("mem_idle", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb},
               0);
    end
    @(posedge clk);
    last_g = g;
    erv = 0; eerr = 0; erd = '0;
    if (!rst_n) begin
      rr_m = 0; own_vld_m = 0; last_g = -1;
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = (k + 1) * 32'h9E3779B9;
    end else if (g >= 0) begin
      erv = 1; eidx = g;
      if (in_rng(a[g])) begin
        idx = int'(a[g] - AST);
        if (we[g]) begin
          for (int b = 0; b < SW; b++) if (s[g][b]) ref_mem[idx][b*8 +: 8] = d[g][b*8 +: 8];
        end else begin
          erd = ref_mem[idx];
        end
`ifdef MEM_ARB_LOCK_EN
        if (lock[g]) begin
          own_vld_m = 1; own_m = g;
        end else if (own_vld_m && own_m == g) begin
          own_vld_m = 0;
        end
`endif
      end else begin
        eerr = 1;
      end
      rr_m = (g + 1) % N;
    end
    @(negedge clk);
    #1;
    check_eq("resp_valid", bus.resp_valid, erv ? (N'(1) << eidx) : '0);
    check_eq("resp_err", bus.resp_err, eerr);
    check_eq("resp_rdata", bus.resp_rdata, erd);
  endtask

  initial begin
    int beats;
    logic [N-1:0] lexp[4];
    v = '0; we = '0; lock = '0;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; s[i] = '0; end
    @(negedge clk);
    #1;
    cycle();
    cycle();
    check_eq("rst_outs", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata,
                          bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wstrb}, 0);
    rst_n = 1'b1;

    // Contention from rr=0: strict alternation
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] || last_g == i) set_req(i, 0, 0, 32'(10 + i), 0, 0);
      cycle();
      check_eq("contend", obs_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    v = '0;
    cycle();

    // Lock burst by req0 (lock 1,1,0) while req1 stays valid
`ifdef MEM_ARB_LOCK_EN
    lexp = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
    lexp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    beats = 1;
    set_req(0, 1, 1, 32'd20, 32'h1111_0000, 4'hF);
    set_req(1, 0, 0, 32'd30, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("lock_seq", obs_ready, lexp[k]);
      if (last_g == 0) begin
        if (beats < 3) set_req(0, 1, beats < 2, 32'(20 + beats), 32'h1111_0000 + beats, 4'hF);
        else v[0] = 1'b0;
        beats++;
      end
      if (last_g == 1) set_req(1, 0, 0, 32'd30, 0, 0);
    end
    v = '0; lock = '0;
    cycle();
    cycle();

    // Single write then read back
    set_req(0, 1, 0, 32'd5, 32'hDEADBEEF, 4'hF);
    cycle();
    set_req(0, 0, 0, 32'd5, 0, 0);
    cycle();
    check_eq("rd_back", bus.resp_rdata, 32'hDEADBEEF);
    v = '0;
    cycle();

    // Out-of-range write at ADDR_END must not touch memory
    set_req(1, 1, 0, 32'd64, 32'hFFFF_FFFF, 4'hF);
    cycle();
    check_eq("oor_resp", {bus.resp_valid, bus.resp_err, bus.resp_rdata}, {2'b10, 1'b1, 32'h0});
    v = '0;
    set_req(0, 0, 0, 32'd0, 0, 0);
    cycle();
    check_eq("word0", bus.resp_rdata, 32'h9E3779B9);
    v = '0;
    cycle();

    // Reset in the cycle after an accept drops the pending response
    set_req(0, 0, 0, 32'd7, 0, 0);
    cycle();
    rst_n = 1'b0;
    set_req(0, 0, 0, 32'd9, 0, 0);
    set_req(1, 0, 0, 32'd8, 0, 0);
    cycle();
    check_eq("mid_rst", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata,
                         bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wstrb}, 0);
    rst_n = 1'b1;
    cycle();
    check_eq("post_rst_first", obs_ready, 2'b01);

    // Randomized traffic; inputs held until accepted
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (v[i] && last_g == i) begin
          if ($urandom_range(0, 3) != 0) rand_req(i);
          else v[i] = 1'b0;
        end else if (!v[i] && $urandom_range(0, 1) == 1) begin
          rand_req(i);
        end
      end
      cycle();
    end
    v = '0;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one single-port, word-addressed data memory between N_REQ requesters: the user-side port of the AXI slave memory device, plus local engines such as DMA or init loaders. Each cycle it grants at most one request and range-checks the word address. It drives the memory port and returns a one-cycle-latency response to the granted requester. Bursts from one requester can be kept atomic with an optional lock.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..8)
- DATA_W, 32, data width
- STRB_W, DATA_W/8, byte-strobe width
- ADDR_W, 32, requester word-address width
- MEM_DEPTH, 64, memory depth in words
- MEM_AW, $clog2(MEM_DEPTH), memory address width
- ADDR_ST, 0, first legal word address (inclusive)
- ADDR_END, 64, last legal word address (exclusive)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  N_REQ  request pending, per requester
- req_ready  out  N_REQ  request accepted this cycle (one-hot or zero)
- req_we  in  N_REQ  1 = write, 0 = read
- req_lock  in  N_REQ  keep grant after this beat (MEM_ARB_LOCK_EN only)
- req_addr  in  N_REQ*ADDR_W  word address; requester i in slice i
- req_wdata  in  N_REQ*DATA_W  write data
- req_wstrb  in  N_REQ*STRB_W  byte strobes
- resp_valid  out  N_REQ  response pulse, per requester
- resp_err  out  1  response was out of range
- resp_rdata  out  DATA_W  read data (0 for writes and errors)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  MEM_AW  req_addr − ADDR_ST, truncated to MEM_AW
- mem_wdata  out  DATA_W  write data
- mem_wstrb  out  STRB_W  byte strobes
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en && !mem_we

## Operation
- State: round-robin pointer `rr` (0..N_REQ−1), lock owner `own` plus `own_vld`, and response registers.
- Grant, combinational:
  - If own_vld, only requester `own` is eligible.
  - Otherwise the eligible requester is the first with req_valid set, searching from rr upward with wrap.
- req_ready[g] = 1 for the granted index g; all other bits are 0. A request is accepted when req_valid[g] && req_ready[g].
- On accept, range check: ADDR_ST ≤ req_addr < ADDR_END.
  - In range: mem_en=1, with mem_we, mem_addr, mem_wdata and mem_wstrb taken from requester g.
  - Out of range: mem_en=0 and no memory side effect.
- rr is updated to (g+1) mod N_REQ on every accept.
- Response register, updated at the clock edge of the accept:
  - resp_valid[g] is set to 1 for one cycle; all other bits are 0.
  - resp_err is set to the range-check failure of the accepted request.
  - A flag records whether the beat was an in-range read.
- resp_rdata = mem_rdata while resp_valid is set and the recorded beat was an in-range read; otherwise 0.
- Requesters cannot stall responses; every response is unconditionally consumed.
- With no accept in a cycle: mem_en=0, and mem_we/addr/wdata/wstrb are 0.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, rr=0, own_vld=0.
- Latency: accept in cycle T → resp_valid in cycle T+1. Throughput is one beat per cycle, including back-to-back beats from different requesters.
- A requester's req_* inputs must stay stable while req_valid=1 and req_ready=0.
- All requesters idle: no grant, and rr is unchanged.
- Simultaneous requests with rr=0 and N_REQ=2: requester 0 wins, then requester 1, then requester 0 (strict alternation).
- Reset asserted mid-operation clears everything the next edge. Any in-flight response is dropped and no resp_valid is produced for it.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - An accepted beat with req_lock=1 sets own=g and own_vld=1.
  - An accepted beat from the owner with req_lock=0 clears own_vld.
  - While locked, other requesters see req_ready=0. rr still advances on the owner's beats.
  - An out-of-range beat does not alter the lock state.
- MEM_ARB_LOCK_EN undefined:
  - req_lock is ignored and own_vld is held at 0.
  - Pure round-robin arbitration.

## Test plan
- Single write then read (N_REQ=2): req0 writes addr 5, data 0xDEADBEEF, strb 0xF → mem_en=1, mem_we=1, mem_addr=5 that cycle; resp_valid=01 next cycle. req0 then reads addr 5 → resp_rdata=0xDEADBEEF with resp_valid=01.
- Contention: req0 and req1 hold valid reads for 4 cycles → grants alternate 0,1,0,1 and resp_valid follows one cycle later, alternating.
- Out of range: req1 writes addr 64 with ADDR_END=64 → mem_en stays 0; next cycle resp_valid=10, resp_err=1, resp_rdata=0. A later read of memory word 0 is unchanged.
- Lock (MEM_ARB_LOCK_EN defined): req0 issues 3 beats with lock=1,1,0 while req1 is valid throughout → req0 gets 3 consecutive grants, then req1 is granted on the 4th cycle.
- Reset mid-flight: assert rst_n=0 in the cycle after an accept → resp_valid=0 at the next edge and all outputs hold reset values. After release, rr=0 and requester 0 wins first.
